// File: rtl/avr_io_in_debounce.sv
// Input-direction AVR I/O port: 2-FF sync, tick-based debounce, rising-edge flags (W1C).
// Optional AVR_IO_IN_IRQ_EN adds a MASK register (sel=0 write) and a registered irq output.
module avr_io_in_debounce #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned DB_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             io_re,
    input  logic             io_we,
    input  logic             io_sel,
    input  logic [7:0]       io_di,
    output logic [7:0]       io_do,
    input  logic [WIDTH-1:0] pins,
    output logic             irq
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned CW = $clog2(DB_COUNT) + 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

    logic [WIDTH-1:0]         sync1;
    logic [WIDTH-1:0]         sync2;
    logic [PW-1:0]            pre;
    logic                     tick;
    logic [WIDTH-1:0]         state;
    logic [WIDTH-1:0]         state_nx;
    logic [WIDTH-1:0][CW-1:0] cnt;
    logic [WIDTH-1:0][CW-1:0] cnt_nx;
    logic [WIDTH-1:0]         rise;
    logic [WIDTH-1:0]         flags;
    logic [WIDTH-1:0]         flags_nx;
    logic [WIDTH-1:0]         clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
        end
    end

    // Per-bit debounce: a new level must persist for DB_COUNT consecutive ticks
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rise     = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (tick) begin
                if (sync2[i] == state[i]) begin
                    cnt_nx[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    state_nx[i] = ~state[i];
                    cnt_nx[i]   = '0;
                    rise[i]     = ~state[i];
                end else begin
                    cnt_nx[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Set has priority over a same-cycle clear
    assign clr      = (io_we && io_sel) ? io_di[WIDTH-1:0] : '0;
    assign flags_nx = (flags & ~clr) | rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= '0;
            cnt   <= '0;
            flags <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            flags <= flags_nx;
        end
    end

    always_comb begin
        io_do = 8'h00;
        if (io_re) begin
            io_do = io_sel ? 8'(flags) : 8'(state);
        end
    end

`ifdef AVR_IO_IN_IRQ_EN
    logic [WIDTH-1:0] mask;
    logic             irq_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask  <= '0;
            irq_q <= 1'b0;
        end else begin
            if (io_we && !io_sel) begin
                mask <= io_di[WIDTH-1:0];
            end
            irq_q <= |(flags & mask);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_avr_io_in_debounce.sv
// Directed bench for avr_io_in_debounce (PRESCALE=4, DB_COUNT=3): vector table plus timing sequences.
module tb_avr_io_in_debounce;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned PRESCALE = 4;
    localparam int unsigned DB_COUNT = 3;

    logic             clk;
    logic             rst;
    logic             io_re;
    logic             io_we;
    logic             io_sel;
    logic [7:0]       io_di;
    logic [7:0]       io_do;
    logic [WIDTH-1:0] pins;
    logic             irq;

    int tests;
    int fails;

    typedef struct {
        logic       re;
        logic       we;
        logic       sel;
        logic [7:0] di;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[13];

    avr_io_in_debounce #(
        .WIDTH(WIDTH), .PRESCALE(PRESCALE), .DB_COUNT(DB_COUNT)
    ) dut (
        .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we), .io_sel(io_sel),
        .io_di(io_di), .io_do(io_do), .pins(pins), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic read_chk(input string name, input logic sel, input logic [7:0] exp);
        io_re  = 1'b1;
        io_sel = sel;
        #1;
        chk(name, io_do, exp);
    endtask

    // Release reset mid-cycle with pins applied, then watch PIN until the third tick accepts it
    task automatic run_from_release(input logic [7:0] p, input logic [7:0] exp);
        @(negedge clk);
        rst  = 1'b1;
        pins = p;
        io_re  = 1'b1;
        io_sel = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("pin_wait_%0d", k), io_do, (k == 11) ? exp : 8'h00);
        end
        read_chk("edge_after_settle", 1'b1, exp);
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst    = 1'b0;
        pins   = '0;
        io_re  = 1'b0;
        io_we  = 1'b0;
        io_sel = 1'b0;
        io_di  = 8'h00;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h05};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h05};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h04, 8'h00};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h01};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h01};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h01};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'h00};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h05};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h01};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 8'h01, 8'h01};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h05};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        read_chk("reset_pin", 1'b0, 8'h00);
        read_chk("reset_edge", 1'b1, 8'h00);
        chk("reset_irq", {7'b0, irq}, 8'h00);

        // Held level accepted on the third tick
        run_from_release(8'h01, 8'h01);
        @(posedge clk);
        #1;
        chk("irq_unmasked", {7'b0, irq}, 8'h00);

        // Six-cycle glitch never reaches three consecutive ticks
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b1;
        pins = '0;
        repeat (2) @(posedge clk);
        #1;
        pins = 8'h01;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) pins = 8'h00;
            read_chk($sformatf("glitch_pin_%0d", k), 1'b0, 8'h00);
            read_chk($sformatf("glitch_edge_%0d", k), 1'b1, 8'h00);
        end

        // Register-map vectors with PIN=EDGE=0x05 settled
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b1;
        pins = 8'h05;
        repeat (16) @(posedge clk);
        #1;
        for (int v = 0; v < 13; v++) begin
            io_re  = tbl[v].re;
            io_we  = tbl[v].we;
            io_sel = tbl[v].sel;
            io_di  = tbl[v].di;
            #1;
            chk($sformatf("vec_%0d", v), io_do, tbl[v].exp);
            @(posedge clk);
            #1;
            io_we = 1'b0;
            io_di = 8'h00;
        end
`ifndef AVR_IO_IN_IRQ_EN
        chk("irq_tied_off", {7'b0, irq}, 8'h00);
`endif

        // Clear of bit 1 lands on the edge where bit 1 debounces high: set wins
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b1;
        pins = 8'h02;
        repeat (11) @(posedge clk);
        #1;
        read_chk("set_wins_pre", 1'b0, 8'h00);
        io_we  = 1'b1;
        io_sel = 1'b1;
        io_di  = 8'h02;
        @(posedge clk);
        #1;
        io_we = 1'b0;
        io_di = 8'h00;
        read_chk("set_wins_edge", 1'b1, 8'h02);
        read_chk("set_wins_pin", 1'b0, 8'h02);

        // Reset while bit 0 is two ticks into its debounce
        pins = 8'h03;
        repeat (8) @(posedge clk);
        #1;
        read_chk("mid_debounce_pin", 1'b0, 8'h02);
        rst = 1'b0;
        #1;
        read_chk("mid_reset_pin", 1'b0, 8'h00);
        read_chk("mid_reset_edge", 1'b1, 8'h00);
        chk("mid_reset_irq", {7'b0, irq}, 8'h00);
        @(posedge clk);
        run_from_release(8'h03, 8'h03);

`ifdef AVR_IO_IN_IRQ_EN
        begin
            logic found;
            found = 1'b0;
            rst = 1'b0;
            @(posedge clk);
            @(negedge clk);
            rst  = 1'b1;
            pins = '0;
            @(posedge clk);
            #1;
            io_we  = 1'b1;
            io_sel = 1'b0;
            io_di  = 8'h02;
            @(posedge clk);
            #1;
            io_we = 1'b0;
            io_di = 8'h00;
            pins  = 8'h01;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk);
                #1;
                chk($sformatf("irq_masked_%0d", k), {7'b0, irq}, 8'h00);
            end
            read_chk("irq_edge0", 1'b1, 8'h01);
            pins = 8'h03;
            for (int k = 0; k < 40 && !found; k++) begin
                @(posedge clk);
                #1;
                read_chk($sformatf("irq_poll_pin_%0d", k), 1'b0, io_do);
                io_sel = 1'b1;
                #1;
                if (io_do[1]) found = 1'b1;
            end
            chk("irq_flag_seen", {7'b0, found}, 8'h01);
            chk("irq_same_cycle", {7'b0, irq}, 8'h00);
            @(posedge clk);
            #1;
            chk("irq_next_cycle", {7'b0, irq}, 8'h01);
            io_we  = 1'b1;
            io_sel = 1'b1;
            io_di  = 8'h02;
            @(posedge clk);
            #1;
            io_we = 1'b0;
            io_di = 8'h00;
            @(posedge clk);
            #1;
            chk("irq_cleared", {7'b0, irq}, 8'h00);
            read_chk("irq_edge_left", 1'b1, 8'h01);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
